// File: rtl/pci_phy_pkg.sv
// rtl/pci_phy_pkg.sv - symbol constants shared by the PCIe PHY lane serializer and deserializer
package pci_phy_pkg;

  localparam int SYM_W     = 8;
  localparam int BIT_CNT_W = 3;

  localparam logic [SYM_W-1:0] COM_SYMBOL = 8'hBC;

  typedef logic [SYM_W-1:0] symbol_t;

endpackage

// File: rtl/paralelo_serial_tx.sv
// rtl/paralelo_serial_tx.sv - byte-to-serial lane transmitter, MSB first, COM preamble and idle fill
// Optional build macro COM_PERIODIC_EN forces a COM after COM_INTERVAL consecutive data symbols.
module paralelo_serial_tx #(
  parameter int               SYM_W        = 8,
  parameter logic [SYM_W-1:0] IDLE_SYMBOL  = pci_phy_pkg::COM_SYMBOL,
  parameter int               NUM_PREAMBLE = 4,
  parameter int               COM_INTERVAL = 16
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [SYM_W-1:0] data_in,
  input  logic             valid_in,
  output logic             ready,
  output logic             data_out,
  output logic             sending_data,
  output logic             tx_active
);

  import pci_phy_pkg::*;

  if (SYM_W != 8 || NUM_PREAMBLE < 1 || NUM_PREAMBLE > 15 ||
      COM_INTERVAL < 1 || COM_INTERVAL > 31) begin : g_bad_cfg
    $error("paralelo_serial_tx: unsupported parameter set");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SYM_W - 1);
  localparam logic [3:0]           PRE_LAST = 4'(NUM_PREAMBLE);

  logic [SYM_W-1:0]     shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [3:0]           pre_cnt;
  logic                 load_edge;
  logic                 pre_done;
  logic                 force_com;
  logic                 accept;

  assign load_edge = (bit_cnt == LAST_BIT);
  assign pre_done  = (pre_cnt == PRE_LAST);

`ifdef COM_PERIODIC_EN
  logic [4:0] data_run;

  assign force_com = (data_run == 5'(COM_INTERVAL));

  // Counts back-to-back data loads; any COM load restarts the run.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_run <= '0;
    end else if (load_edge) begin
      data_run <= accept ? data_run + 5'd1 : '0;
    end
  end
`else
  assign force_com = 1'b0;
`endif

  assign ready    = load_edge && pre_done && !force_com;
  assign accept   = ready && valid_in;
  assign data_out = shift_reg[SYM_W-1];

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      shift_reg    <= IDLE_SYMBOL;
      bit_cnt      <= '0;
      pre_cnt      <= 4'd1;
      sending_data <= 1'b0;
      tx_active    <= 1'b0;
    end else if (load_edge) begin
      bit_cnt      <= '0;
      shift_reg    <= accept ? data_in : IDLE_SYMBOL;
      sending_data <= accept;
      // pre_cnt holds at NUM_PREAMBLE once the preamble is done
      if (!pre_done) begin
        pre_cnt <= pre_cnt + 4'd1;
      end else begin
        tx_active <= 1'b1;
      end
    end else begin
      shift_reg <= {shift_reg[SYM_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb/tb_paralelo_serial_tx.sv - scoreboard bench for paralelo_serial_tx (honours COM_PERIODIC_EN)
module tb_paralelo_serial_tx;
  import pci_phy_pkg::*;

  localparam int NUM_PRE = 4;
  localparam int COM_INT = 16;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready;
  logic       data_out;
  logic       sending_data;
  logic       tx_active;

  always #5 clk_32f = ~clk_32f;

  paralelo_serial_tx #(
    .SYM_W       (8),
    .IDLE_SYMBOL (8'hBC),
    .NUM_PREAMBLE(NUM_PRE),
    .COM_INTERVAL(COM_INT)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready       (ready),
    .data_out    (data_out),
    .sending_data(sending_data),
    .tx_active   (tx_active)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    int         rise_at;
  } vec_t;

  typedef struct {
    logic [7:0] sym;
    logic       is_data;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int         tests  = 0;
  int         failed = 0;
  int         cyc    = 0;
  int         slot   = 1;
  int         run_m  = 0;
  logic       exp_rdy = 1'b0;
  logic [7:0] rx      = 8'h00;

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, int ra);
    vec_t x;
    x.rst     = r;
    x.valid   = v;
    x.data    = d;
    x.rise_at = ra;
    return x;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Sample at the current negedge, then advance one bit period.
  task automatic step();
    exp_t e;
    rx = {rx[6:0], data_out};
    chk("ready", 8'(ready), 8'((cyc % 8 == 7) && exp_rdy));
    chk("tx_active", 8'(tx_active), 8'(cyc >= 8 * NUM_PRE));
    if (cyc % 8 == 7) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL scoreboard_empty cyc=%0d: got symbol %h, expected none queued", cyc, rx);
      end else begin
        e = exp_q.pop_front();
        chk("symbol", rx, e.sym);
        chk("sending_data", 8'(sending_data), 8'(e.is_data));
      end
    end
    @(posedge clk_32f);
    cyc++;
    @(negedge clk_32f);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    #1;
    chk("rst_data_out", 8'(data_out), 8'h01);
    chk("rst_ready", 8'(ready), 8'h00);
    chk("rst_sending_data", 8'(sending_data), 8'h00);
    chk("rst_tx_active", 8'(tx_active), 8'h00);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    cyc   = 0;
    slot  = 1;
    run_m = 0;
    rx    = 8'h00;
    exp_q.delete();
    exp_q.push_back('{COM_SYMBOL, 1'b0});
  endtask

  // Drive one 8-cycle symbol slot and queue what the line must carry in the next slot.
  task automatic drive_slot(input vec_t v);
    logic force_m;
    logic acc;
`ifdef COM_PERIODIC_EN
    force_m = (run_m == COM_INT);
`else
    force_m = 1'b0;
`endif
    exp_rdy = (slot >= NUM_PRE) && !force_m;
    acc     = v.valid && exp_rdy;
    exp_q.push_back('{acc ? v.data : COM_SYMBOL, acc});
    run_m = acc ? run_m + 1 : 0;
    for (int b = 0; b < 8; b++) begin
      if (v.valid && b == v.rise_at) begin
        valid_in = 1'b1;
        data_in  = v.data;
      end else if (b == 0) begin
        valid_in = 1'b0;
      end
      step();
    end
    slot++;
  endtask

  initial begin
    // idle after reset: eight COMs, preamble timing of ready/tx_active
    vecs.push_back(mk(1, 0, 8'h00, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(0, 0, 8'h00, 0));
    // byte held from reset is ignored through the preamble, then sent once
    vecs.push_back(mk(1, 1, 8'hA5, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 8'hA5, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0));
    // back-to-back bytes
    vecs.push_back(mk(1, 0, 8'h00, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h12, 0));
    vecs.push_back(mk(0, 1, 8'h34, 0));
    vecs.push_back(mk(0, 1, 8'h56, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0));
    // valid rising mid-symbol, at the last bit, and 0xBC as data
    vecs.push_back(mk(0, 1, 8'h81, 3));
    vecs.push_back(mk(0, 1, 8'h5A, 7));
    vecs.push_back(mk(0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hBC, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0));

    #2;
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        assert_reset();
        release_reset();
      end
      drive_slot(vecs[i]);
    end

    // reset at cycle 45 while a data symbol is on the line
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) drive_slot(mk(0, 1, 8'h77, 0));
    drive_slot(mk(0, 1, 8'h3C, 0));
    exp_rdy = 1'b0;
    repeat (5) step();
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) drive_slot(mk(0, 1, 8'h3C, 0));
    drive_slot(mk(0, 0, 8'h00, 0));
    drive_slot(mk(0, 0, 8'h00, 0));

    // long continuous stream: forced COM only when COM_PERIODIC_EN is built in
    assert_reset();
    release_reset();
    for (int i = 0; i < 24; i++) drive_slot(mk(0, 1, 8'(i + 1), 0));
    drive_slot(mk(0, 0, 8'h00, 0));
    drive_slot(mk(0, 0, 8'h00, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
